sfx_arbiter: RTL and testbench
==============================

// Module: sfx_arbiter
// PURPOSE
//   Shares the single PMOD audio channel between gameplay sound requesters
//   (P1 honk, P2 honk, P1 boost, P2 boost).
//   Sits between OperationEncoder and AudioEncoder. Edge-detects requests,
//   queues them and grants them round-robin. Each grant plays a fixed-length
//   tone slot followed by a silent gap.
//   Sound is only produced while the game FSM is in COUNTDOWN or RACING.
// PARAMETERS
//   NUM_REQ          4           number of requesters (>=2)
//   PLAY_CYCLES      20_000_000  clk cycles one sound slot lasts (200 ms @100 MHz, >=1)
//   GAP_CYCLES       2_000_000   silent clk cycles after each slot (>=1)
//   COOLDOWN_CYCLES  50_000_000  per-requester lockout from grant (SFX_COOLDOWN_EN only)
// PORTS
//   clk         in   1                 system clock (100 MHz)
//   rst         in   1                 asynchronous reset, active-high
//   state       in   3                 game FSM state; 3=COUNTDOWN, 4=RACING enable sound
//   req         in   NUM_REQ           level requests, synchronous to clk; bit i = requester i
//   sfx_active  out  1                 high while a sound slot plays
//   sfx_id      out  $clog2(NUM_REQ)   requester owning the current/last slot
//   sfx_grant   out  1                 one-cycle pulse on the cycle a slot starts
//   busy        out  1                 high in PLAY or GAP
// BEHAVIOUR
//   Reset (async): sfx_active=0, sfx_id=0, sfx_grant=0, busy=0, FSM=IDLE,
//     pending=0, req_d=0, counter=0, RR pointer=NUM_REQ-1 (req[0] wins first).
//   en = (state==3)||(state==4).
//   Edge detect: rise[i] = req[i] & ~req_d[i]; req_d is registered every cycle.
//     A held level produces one request only.
//   pending[i] is set on rise[i] when en=1 and cleared on the grant of i.
//     A rise during i's own slot re-queues i.
//     If grant and rise of the same i occur in one cycle, the rise wins (pending stays 1).
//   FSM IDLE -> PLAY: when en and |pending.
//     Winner = first pending index after the RR pointer (modulo NUM_REQ).
//     Registered: sfx_active=1, sfx_id=winner, sfx_grant=1 (one cycle),
//     RR pointer=winner, counter=PLAY_CYCLES-1.
//   PLAY: counter decrements. At counter==0 -> GAP, sfx_active=0, counter=GAP_CYCLES-1.
//   GAP: counter decrements. At counter==0 -> IDLE. The next grant is possible
//     on the following edge, so there are exactly GAP_CYCLES+1 silent cycles
//     between back-to-back slots.
//   Latency: req first sampled high at edge k (idle, en) -> pending at k
//     -> sfx_active/sfx_grant high after edge k+1.
//   Slot length: sfx_active high for exactly PLAY_CYCLES cycles.
//   en=0 (IDLE/SETTING/PAUSE/FINISH), from any state, at the next edge:
//     FSM=IDLE, sfx_active=0, busy=0, pending cleared, rises ignored.
//     sfx_id and the RR pointer are held. No queued sound replays when en returns.
//   Simultaneous rises are all queued and served in RR order, one slot each.
//   Counter width: $clog2(max(PLAY,GAP,COOLDOWN)+1), unsigned. No wrap:
//     the counter is reloaded on every state entry.
//   busy = (FSM!=IDLE), registered.
// CONFIGURATION
//   SFX_COOLDOWN_EN defined:
//     Each requester has its own down-counter, loaded with COOLDOWN_CYCLES-1 on its grant.
//     rise[i] is ignored while that counter is nonzero. The counter also decrements when en=0.
//     Reset value is 0.
//   SFX_COOLDOWN_EN undefined:
//     No cooldown logic is generated and COOLDOWN_CYCLES is unused.
//     Behaviour is otherwise identical.
// TESTING (PLAY_CYCLES=8, GAP_CYCLES=2, COOLDOWN_CYCLES=30, NUM_REQ=4)
//   Async reset asserted mid-PLAY -> all outputs 0 immediately, without a clock edge;
//     after release, idle.
//   state=4, req[1] rises at edge k -> sfx_grant=1 and sfx_active=1, sfx_id=1 after k+1;
//     active 8 cycles; busy for 8+2 cycles.
//   state=4, req[0] and req[2] rise together -> slot id0 (8 cycles), 3 silent cycles,
//     then slot id2 (8 cycles).
//   state=4, req[3] held high for 100 cycles -> exactly one slot, id3.
//   PLAY running, state changes 4->5 -> sfx_active=0 at the next edge, pending cleared;
//     state back to 4 with no new rise -> no slot.
//   req[2] pulses again 12 cycles after its grant:
//     with SFX_COOLDOWN_EN -> ignored, no second slot;
//     without -> second id2 slot granted.

Source files
------------

// File: rtl/sfx_arbiter.sv
// sfx_arbiter: shares the single audio channel between gameplay sound
// requesters. Request rising edges are queued and granted round-robin;
// each grant plays a fixed-length tone slot followed by a silent gap.
// Sound is only produced while the game is in COUNTDOWN (3) or RACING (4).
// Optional feature macro: SFX_COOLDOWN_EN adds a per-requester lockout
// (COOLDOWN_CYCLES) that starts at each grant of that requester.
module sfx_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int PLAY_CYCLES     = 20_000_000,
    parameter int GAP_CYCLES      = 2_000_000,
    parameter int COOLDOWN_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 state,
    input  logic [NUM_REQ-1:0]         req,
    output logic                       sfx_active,
    output logic [$clog2(NUM_REQ)-1:0] sfx_id,
    output logic                       sfx_grant,
    output logic                       busy
);

    localparam int IDW     = $clog2(NUM_REQ);
    localparam int MAX_PG  = (PLAY_CYCLES > GAP_CYCLES) ? PLAY_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_PG > COOLDOWN_CYCLES) ? MAX_PG : COOLDOWN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(PLAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               active_q, active_d;
    logic               grant_q, grant_d;
    logic               busy_q, busy_d;

    logic               en;
    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] cd_block;
    logic [NUM_REQ-1:0] grant_mask;
    logic [IDW-1:0]     winner;
    logic               any_pending;
    logic               do_grant;

    assign en   = (state == 3'd3) || (state == 3'd4);
    // A rise is only accepted when its requester is not locked out.
    assign rise = req & ~req_q & ~cd_block;
    assign any_pending = |pending_q;

    // Round-robin search: first pending index after the last winner.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_v;
        logic           found;
        idx    = 0;
        idx_v  = '0;
        found  = 1'b0;
        winner = rr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(rr_q) + k) % NUM_REQ;
            idx_v = IDW'(idx);
            if (!found && pending_q[idx_v]) begin
                found  = 1'b1;
                winner = idx_v;
            end
        end
    end

    // Slot FSM next state: grant from IDLE, time the tone, then time the gap.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        id_d     = id_q;
        active_d = active_q;
        grant_d  = 1'b0;
        do_grant = 1'b0;
        if (!en) begin
            // Sound disabled: drop the slot immediately, keep id and pointer.
            fsm_d    = S_IDLE;
            active_d = 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (any_pending) begin
                        do_grant = 1'b1;
                        fsm_d    = S_PLAY;
                        cnt_d    = PLAY_LOAD;
                        rr_d     = winner;
                        id_d     = winner;
                        active_d = 1'b1;
                        grant_d  = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (cnt_q == '0) begin
                        fsm_d    = S_GAP;
                        cnt_d    = GAP_LOAD;
                        active_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        fsm_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    fsm_d    = S_IDLE;
                    active_d = 1'b0;
                end
            endcase
        end
        busy_d = (fsm_d != S_IDLE);
    end

    // One-hot view of the requester being granted this cycle.
    always_comb begin
        grant_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_mask[i] = do_grant && (winner == IDW'(i));
        end
    end

    // Pending queue: a same-cycle rise overrides the clear from a grant.
    always_comb begin
        pending_d = '0;
        if (en) begin
            pending_d = (pending_q & ~grant_mask) | rise;
        end
    end

    // State, counter, queue and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            pending_q <= '0;
            rr_q      <= IDW'(NUM_REQ - 1);
            id_q      <= '0;
            active_q  <= 1'b0;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            req_q     <= req;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            active_q  <= active_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

`ifdef SFX_COOLDOWN_EN
    logic [CNT_W-1:0] cd_q [NUM_REQ];
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    // Per-requester lockout counters; they keep running while sound is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_mask[i]) begin
                    cd_q[i] <= CD_LOAD;
                end else if (cd_q[i] != '0) begin
                    cd_q[i] <= cd_q[i] - CNT_ONE;
                end
            end
        end
    end

    // A requester is locked out while its counter is nonzero.
    always_comb begin
        cd_block = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cd_block[i] = (cd_q[i] != '0);
        end
    end
`else
    assign cd_block = '0;
`endif

    assign sfx_active = active_q;
    assign sfx_id     = id_q;
    assign sfx_grant  = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Bench for sfx_arbiter: directed request patterns; expected grants are queued
// when stimulus is issued and checked by a monitor on every grant pulse.
module tb_sfx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PLAY    = 8;
    localparam int GAP     = 2;
    localparam int COOL    = 30;

    logic       clk;
    logic       rst;
    logic [2:0] state;
    logic [3:0] req;
    logic       sfx_active;
    logic [1:0] sfx_id;
    logic       sfx_grant;
    logic       busy;

    sfx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .PLAY_CYCLES    (PLAY),
        .GAP_CYCLES     (GAP),
        .COOLDOWN_CYCLES(COOL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .req       (req),
        .sfx_active(sfx_active),
        .sfx_id    (sfx_id),
        .sfx_grant (sfx_grant),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int len;   // expected slot length, -1 when the slot is cut short
        int gap;   // expected silent cycles before this slot, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_slot(input int id, input int len, input int gap);
        exp_t e;
        e.id  = id;
        e.len = len;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Wait until every queued grant has been seen and the arbiter is idle.
    task automatic drain(input int budget);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < budget) begin
            tick(1);
            cyc++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // Monitor: pop on each grant pulse, then measure slot, busy and gap lengths.
    initial begin
        exp_t cur;
        bit   in_slot;
        bit   in_busy;
        int   act_len;
        int   busy_len;
        int   silent;
        cur.id = 0; cur.len = -1; cur.gap = -1;
        in_slot = 0; in_busy = 0; act_len = 0; busy_len = 0; silent = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_slot = 0;
                in_busy = 0;
                silent  = -1;
            end else begin
                if (sfx_grant) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got grant id %0d, expected no grant (t=%0t)", sfx_id, $time);
                        cur.id = -1; cur.len = -1; cur.gap = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant_id", sfx_id, cur.id);
                        chk("grant_active", sfx_active, 1);
                        chk("grant_busy", busy, 1);
                        if (cur.gap >= 0) chk("silent_gap", silent, cur.gap);
                    end
                    in_slot  = 1;
                    in_busy  = 1;
                    act_len  = 0;
                    busy_len = 0;
                end
                if (in_slot) begin
                    if (sfx_active) begin
                        act_len++;
                    end else begin
                        in_slot = 0;
                        silent  = 1;
                        if (cur.len >= 0) chk("slot_len", act_len, cur.len);
                    end
                end else if (!sfx_active && silent >= 0) begin
                    silent++;
                end
                if (in_busy) begin
                    if (busy) begin
                        busy_len++;
                    end else begin
                        in_busy = 0;
                        if (cur.len >= 0) chk("busy_len", busy_len, cur.len + GAP);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        state = 3'd0;
        req   = 4'b0000;
        tick(3);
        chk("reset_active", sfx_active, 0);
        chk("reset_id", sfx_id, 0);
        chk("reset_grant", sfx_grant, 0);
        chk("reset_busy", busy, 0);
        rst   = 1'b0;
        state = 3'd4;
        tick(3);
        chk("idle_busy", busy, 0);

        // Simultaneous rises from reset pointer: id0 first, then id2 after 3 silent cycles.
        req = 4'b0101;
        expect_slot(0, PLAY, -1);
        expect_slot(2, PLAY, GAP + 1);
        tick(1);
        req = 4'b0000;
        drain(100);
        tick(10);

        // Single rise: grant exactly one edge after the rise is sampled.
        req = 4'b0010;
        expect_slot(1, PLAY, -1);
        tick(1);
        chk("latency_no_grant_yet", sfx_grant, 0);
        tick(1);
        chk("latency_grant", sfx_grant, 1);
        chk("latency_active", sfx_active, 1);
        chk("latency_id", sfx_id, 1);
        req = 4'b0000;
        tick(1);
        chk("grant_one_cycle", sfx_grant, 0);
        drain(100);
        tick(10);

        // Held level: one slot only.
        req = 4'b1000;
        expect_slot(3, PLAY, -1);
        tick(100);
        req = 4'b0000;
        drain(100);
        tick(10);

        // Pointer at 3: requests 0 and 3 wrap so 0 goes first.
        req = 4'b1001;
        expect_slot(0, PLAY, -1);
        expect_slot(3, PLAY, GAP + 1);
        tick(1);
        req = 4'b0000;
        drain(100);
        tick(10);

        // Disable mid-PLAY with another request pending; nothing replays.
        req = 4'b0001;
        expect_slot(0, -1, -1);
        tick(1);
        req = 4'b0000;
        tick(3);
        req = 4'b0010;
        tick(1);
        req = 4'b0000;
        tick(1);
        state = 3'd5;
        tick(1);
        chk("disable_active", sfx_active, 0);
        chk("disable_busy", busy, 0);
        chk("disable_id_held", sfx_id, 0);
        req = 4'b0100;
        tick(1);
        req = 4'b0000;
        tick(2);
        state = 3'd4;
        tick(30);
        chk("reenable_busy", busy, 0);
        chk("reenable_active", sfx_active, 0);

        // Repeat pulse 12 cycles after a grant: cooldown decides.
        req = 4'b0100;
        expect_slot(2, PLAY, -1);
        tick(1);
        req = 4'b0000;
        tick(1);
        chk("cool_first_grant", sfx_grant, 1);
        tick(11);
        req = 4'b0100;
`ifndef SFX_COOLDOWN_EN
        expect_slot(2, PLAY, -1);
`endif
        tick(1);
        req = 4'b0000;
        drain(100);
        tick(20);
        chk("cool_idle_after", busy, 0);
        tick(40);

        // Async reset mid-PLAY clears outputs without a clock edge.
        req = 4'b0001;
        expect_slot(0, -1, -1);
        tick(1);
        req = 4'b0000;
        tick(4);
        chk("pre_reset_active", sfx_active, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_active", sfx_active, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_grant", sfx_grant, 0);
        chk("async_rst_id", sfx_id, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_active", sfx_active, 0);

        // Pointer returns to NUM_REQ-1 after reset: id0 before id1.
        req = 4'b0011;
        expect_slot(0, PLAY, -1);
        expect_slot(1, PLAY, GAP + 1);
        tick(1);
        req = 4'b0000;
        drain(100);
        tick(10);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
